// File: rtl/program_loader_pkg.sv
// Shared constants and state encoding for the UART program loader.
package program_loader_pkg;

    localparam logic [5:0] OP_EOP = 6'b111111;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WRITE,
        DONE,
        ERR
    } loadState_t;

endpackage

// File: rtl/program_loader_word_assembler.sv
// Byte-to-word shift register, MSB byte first, with a 2-bit byte index.
module word_assembler
    import program_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        shiftEn,
    input  logic [7:0]  data,
    output logic [31:0] nextWord,
    output logic        wordReady
);

    logic [23:0] shiftReg;
    logic [1:0]  byteIdx;

    // The 4th byte goes straight into the word; only 3 bytes are stored.
    assign nextWord  = {shiftReg, data};
    assign wordReady = shiftEn && (byteIdx == 2'd3);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shiftReg <= '0;
            byteIdx  <= '0;
        end else if (clear) begin
            shiftReg <= '0;
            byteIdx  <= '0;
        end else if (shiftEn) begin
            shiftReg <= {shiftReg[15:0], data};
            byteIdx  <= byteIdx + 2'd1;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Loads a program from a UART byte stream into instruction memory,
// holding the CPU in reset until the End-of-Program word is written.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              cpu_hold,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    loadState_t  state;
    logic        restart;
    logic        isEop;
    logic        lastWord;
    logic        shiftEn;
    logic        wordReady;
    logic [31:0] nextWord;

    assign restart  = start && (state == IDLE || state == DONE || state == ERR);
    assign isEop    = (imem_wdata[31:26] == OP_EOP);
    assign lastWord = isEop || (imem_addr == LAST_ADDR);
    // A byte arriving during a non-terminal write starts the next word.
    assign shiftEn  = rx_valid
                   && ((state == RECV) || (state == WRITE && !lastWord));

    word_assembler u_asm (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (restart),
        .shiftEn  (shiftEn),
        .data     (rx_data),
        .nextWord (nextWord),
        .wordReady(wordReady)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            cpu_hold   <= 1'b1;
            word_count <= '0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state      <= RECV;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        cpu_hold   <= 1'b1;
                        word_count <= '0;
                        imem_addr  <= '0;
                    end
                end
                RECV: begin
                    if (wordReady) begin
                        state      <= WRITE;
                        imem_we    <= 1'b1;
                        imem_wdata <= nextWord;
                    end
                end
                WRITE: begin
                    word_count <= word_count + COUNT_ONE;
                    if (isEop) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                        busy     <= 1'b0;
                    end else if (imem_addr == LAST_ADDR) begin
                        state <= ERR;
                        error <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        state     <= RECV;
                        imem_addr <= imem_addr + ADDR_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench: directed table, corner sequences, random vs model.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rstN;
    logic        start;
    logic        rxValid;
    logic [7:0]  rxData;

    logic        weA, busyA, doneA, errA, holdA;
    logic [9:0]  addrA;
    logic [31:0] wdA;
    logic [10:0] wcA;

    logic        weB, busyB, doneB, errB, holdB;
    logic [1:0]  addrB;
    logic [31:0] wdB;
    logic [2:0]  wcB;

    program_loader dutA (
        .clk(clk), .rst_n(rstN), .start(start),
        .rx_valid(rxValid), .rx_data(rxData),
        .imem_we(weA), .imem_addr(addrA), .imem_wdata(wdA),
        .busy(busyA), .done(doneA), .error(errA),
        .cpu_hold(holdA), .word_count(wcA)
    );

    program_loader #(.ADDR_W(2)) dutB (
        .clk(clk), .rst_n(rstN), .start(start),
        .rx_valid(rxValid), .rx_data(rxData),
        .imem_we(weB), .imem_addr(addrB), .imem_wdata(wdB),
        .busy(busyB), .done(doneB), .error(errB),
        .cpu_hold(holdB), .word_count(wcB)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nErr    = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [41:0] gotQ0[$], gotQ1[$], expQ0[$], expQ1[$];
    logic        prevWeA = 1'b0;
    logic        prevWeB = 1'b0;

    always @(negedge clk) begin
        if (weA === 1'b1) begin
            gotQ0.push_back({addrA, wdA});
            check("we_twice_A", prevWeA, 0);
        end
        if (weB === 1'b1) begin
            gotQ1.push_back({8'b0, addrB, wdB});
            check("we_twice_B", prevWeB, 0);
        end
        prevWeA = (weA === 1'b1);
        prevWeB = (weB === 1'b1);
    end

    // Load-level model: accepted bytes form words; a load ends on an
    // EOP word or when capacity is reached. The write follows the 4th byte.
    bit          act[2], wcy[2], dn[2], er[2];
    int          nb[2], cnt[2];
    logic [31:0] acc[2];

    task automatic modelStep(input logic s, input logic v,
                             input logic [7:0] d);
        for (int k = 0; k < 2; k++) begin
            int cap;
            bit wasW;
            cap = (k == 0) ? 1024 : 4;
            wasW = wcy[k];
            wcy[k] = 0;
            if (!rstN) begin
                act[k] = 0; dn[k] = 0; er[k] = 0;
                cnt[k] = 0; nb[k] = 0; acc[k] = '0;
            end else if (s && !act[k] && !wasW) begin
                act[k] = 1; dn[k] = 0; er[k] = 0;
                cnt[k] = 0; nb[k] = 0; acc[k] = '0;
            end else if (v && act[k]) begin
                acc[k] = {acc[k][23:0], d};
                nb[k]++;
                if (nb[k] == 4) begin
                    nb[k] = 0;
                    if (k == 0) expQ0.push_back({cnt[k][9:0], acc[k]});
                    else expQ1.push_back({8'b0, cnt[k][1:0], acc[k]});
                    cnt[k]++;
                    wcy[k] = 1;
                    if (acc[k][31:26] == 6'b111111) begin
                        act[k] = 0; dn[k] = 1;
                    end else if (cnt[k] == cap) begin
                        act[k] = 0; er[k] = 1;
                    end
                end
            end
        end
    endtask

    task automatic cyc(input logic s, input logic v, input logic [7:0] d);
        start = s; rxValid = v; rxData = d;
        modelStep(s, v, d);
        @(posedge clk);
        #1;
        start = 1'b0; rxValid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00);
    endtask

    task automatic sendWord(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3,
                            input int gap);
        logic [7:0] bs[4];
        bs = '{b0, b1, b2, b3};
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, bs[i]);
            idle(gap);
        end
    endtask

    task automatic doReset();
        rstN = 1'b0;
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        rstN = 1'b1;
    endtask

    task automatic statusCheck(input string tag);
        int n;
        idle(2);
        check({tag, ":doneA"}, doneA, dn[0]);
        check({tag, ":errA"}, errA, er[0]);
        check({tag, ":holdA"}, holdA, !dn[0]);
        check({tag, ":busyA"}, busyA, act[0]);
        check({tag, ":countA"}, wcA, cnt[0]);
        check({tag, ":doneB"}, doneB, dn[1]);
        check({tag, ":errB"}, errB, er[1]);
        check({tag, ":holdB"}, holdB, !dn[1]);
        check({tag, ":busyB"}, busyB, act[1]);
        check({tag, ":countB"}, wcB, cnt[1]);
        check({tag, ":nwrA"}, gotQ0.size(), expQ0.size());
        check({tag, ":nwrB"}, gotQ1.size(), expQ1.size());
        n = (gotQ0.size() < expQ0.size()) ? gotQ0.size() : expQ0.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s:wrA%0d", tag, i), gotQ0[i], expQ0[i]);
        n = (gotQ1.size() < expQ1.size()) ? gotQ1.size() : expQ1.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s:wrB%0d", tag, i), gotQ1[i], expQ1[i]);
        gotQ0.delete(); gotQ1.delete();
        expQ0.delete(); expQ1.delete();
    endtask

    typedef struct {
        logic        rs;
        logic [7:0]  b0, b1, b2, b3;
        logic [9:0]  expAddr;
        logic [31:0] expWord;
        logic        expDone;
    } vec_t;

    vec_t tbl[5];

    initial begin
        logic [41:0] last;
        logic [7:0]  d;
        int          r;

        tbl[0] = '{1'b1, 8'h20, 8'h01, 8'h00, 8'h05, 10'd0, 32'h20010005, 1'b0};
        tbl[1] = '{1'b0, 8'hFC, 8'h00, 8'h00, 8'h00, 10'd1, 32'hFC000000, 1'b1};
        tbl[2] = '{1'b1, 8'h3F, 8'hFF, 8'hFF, 8'hFF, 10'd0, 32'h3FFFFFFF, 1'b0};
        tbl[3] = '{1'b0, 8'h12, 8'h34, 8'h56, 8'h78, 10'd1, 32'h12345678, 1'b0};
        tbl[4] = '{1'b0, 8'hFF, 8'h00, 8'h00, 8'h01, 10'd2, 32'hFF000001, 1'b1};

        rstN = 1'b0; start = 1'b0; rxValid = 1'b0; rxData = 8'h00;
        doReset();

        check("rst_we", weA, 0);
        check("rst_addr", addrA, 0);
        check("rst_wdata", wdA, 0);
        check("rst_busy", busyA, 0);
        check("rst_done", doneA, 0);
        check("rst_err", errA, 0);
        check("rst_hold", holdA, 1);
        check("rst_count", wcA, 0);
        check("rst_holdB", holdB, 1);

        // Bytes before any start must be ignored.
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'h11);

        for (int i = 0; i < 5; i++) begin
            if (tbl[i].rs) begin
                idle(1);
                cyc(1'b1, 1'b1, 8'hEE);
            end
            sendWord(tbl[i].b0, tbl[i].b1, tbl[i].b2, tbl[i].b3, 1);
            idle(2);
            last = (gotQ0.size() > 0) ? gotQ0[$] : '1;
            check($sformatf("tbl%0d_write", i), last,
                  {tbl[i].expAddr, tbl[i].expWord});
            check($sformatf("tbl%0d_done", i), doneA, tbl[i].expDone);
            check($sformatf("tbl%0d_hold", i), holdA, !tbl[i].expDone);
            if (tbl[i].expDone)
                for (int j = 0; j < 3; j++) cyc(1'b0, 1'b1, 8'h44);
        end
        statusCheck("table");

        // Overflow: the 2-bit-address instance fills after 4 words.
        idle(1);
        cyc(1'b1, 1'b0, 8'h00);
        for (int w = 0; w < 4; w++)
            sendWord(8'(w + 1), 8'h10, 8'h20, 8'h30, 1);
        idle(2);
        check("ovf_errB", errB, 1);
        check("ovf_holdB", holdB, 1);
        check("ovf_nwrB", gotQ1.size(), 4);
        sendWord(8'h05, 8'h10, 8'h20, 8'h30, 0);
        idle(2);
        check("ovf_no5thB", gotQ1.size(), 4);
        check("ovf_5thA", gotQ0.size(), 5);
        statusCheck("overflow");

        // Mid-word reset discards the partial word.
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 8'h99);
        cyc(1'b0, 1'b1, 8'h88);
        doReset();
        statusCheck("midrst");
        cyc(1'b1, 1'b0, 8'h00);
        sendWord(8'hAA, 8'hBB, 8'hCC, 8'hDD, 1);
        idle(2);
        last = (gotQ0.size() == 1) ? gotQ0[0] : '1;
        check("midrst_write", last, {10'd0, 32'hAABBCCDD});
        statusCheck("midrst2");

        // Back-to-back bytes, including during the write cycles.
        doReset();
        cyc(1'b1, 1'b0, 8'h00);
        sendWord(8'h01, 8'h02, 8'h03, 8'h04, 0);
        sendWord(8'hFD, 8'h11, 8'h22, 8'h33, 0);
        cyc(1'b0, 1'b1, 8'h44);
        idle(2);
        check("b2b_nwr", gotQ0.size(), 2);
        last = (gotQ0.size() > 1) ? gotQ0[1] : '1;
        check("b2b_word1", last, {10'd1, 32'hFD112233});
        check("b2b_done", doneA, 1);
        statusCheck("b2b");

        for (int it = 0; it < 10; it++) begin
            idle(1);
            cyc(1'b1, 1'b0, 8'h00);
            for (int c = 0; c < 200; c++) begin
                r = $urandom_range(0, 99);
                d = 8'($urandom);
                if ($urandom_range(0, 7) == 0) d = d | 8'hFC;
                if (r < 1 && (it % 2) == 1) begin
                    rstN = 1'b0;
                    cyc(1'b0, 1'b0, 8'h00);
                    rstN = 1'b1;
                end else begin
                    cyc(r < 4, $urandom_range(0, 2) != 0, d);
                end
            end
            statusCheck($sformatf("rand%0d", it));
        end

        $display("Result: errors=%0d of %0d checks", nErr, nChecks);
        $finish;
    end

endmodule
